// File: rtl/riscv_rf_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port between
// several writeback sources, with a single registered output stage.
module riscv_rf_wb_arbiter #(
   parameter int WORD_LENGTH = 32,
   parameter int ADDR_LENGTH = 5,
   parameter int NUM_REQ     = 3
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           stall,
   input  logic [NUM_REQ-1:0]             req_valid,
   input  logic [NUM_REQ*ADDR_LENGTH-1:0] req_addr,
   input  logic [NUM_REQ*WORD_LENGTH-1:0] req_data,
   output logic [NUM_REQ-1:0]             req_ready,
   output logic                           rf_write_en,
   output logic [ADDR_LENGTH-1:0]         rf_write_addr,
   output logic [WORD_LENGTH-1:0]         rf_data,
   output logic [$clog2(NUM_REQ)-1:0]     grant_id
);

   localparam int   GW         = $clog2(NUM_REQ);
   localparam logic RF_WRITE   = 1'b1;
   localparam logic RF_NOWRITE = 1'b0;

   logic [GW-1:0]          ptr_q, ptr_d;
   logic                   wen_q, wen_d;
   logic [ADDR_LENGTH-1:0] addr_q, addr_d;
   logic [WORD_LENGTH-1:0] data_q, data_d;
   logic [GW-1:0]          gid_q, gid_d;

   logic                   gnt_vld;
   logic [GW-1:0]          gnt_idx;
   logic                   xfer;

   // Scan sources starting at the priority pointer; first valid one wins.
   always_comb begin
      int idx;
      gnt_vld = 1'b0;
      gnt_idx = '0;
      idx     = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = int'(ptr_q) + k;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (!gnt_vld && req_valid[idx]) begin
            gnt_vld = 1'b1;
            gnt_idx = GW'(idx);
         end
      end
   end

   // Grant is suppressed during stall and while reset is held.
   always_comb begin
      xfer      = gnt_vld && !stall && !rst;
      req_ready = '0;
      if (xfer) req_ready[gnt_idx] = 1'b1;
   end

   // Next-state for the output stage and the priority pointer.
   always_comb begin
      ptr_d  = ptr_q;
      wen_d  = RF_NOWRITE;
      addr_d = addr_q;
      data_d = data_q;
      gid_d  = gid_q;
      if (xfer) begin
         addr_d = req_addr[gnt_idx*ADDR_LENGTH +: ADDR_LENGTH];
         data_d = req_data[gnt_idx*WORD_LENGTH +: WORD_LENGTH];
         gid_d  = gnt_idx;
         // Writes to x0 are accepted but never reach the RF.
         wen_d  = (addr_d != '0) ? RF_WRITE : RF_NOWRITE;
         if (gnt_idx == GW'(NUM_REQ - 1)) ptr_d = '0;
         else                             ptr_d = gnt_idx + GW'(1);
      end
   end

   // Output stage and pointer registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_q  <= '0;
         wen_q  <= RF_NOWRITE;
         addr_q <= '0;
         data_q <= '0;
         gid_q  <= '0;
      end else begin
         ptr_q  <= ptr_d;
         wen_q  <= wen_d;
         addr_q <= addr_d;
         data_q <= data_d;
         gid_q  <= gid_d;
      end
   end

   assign rf_write_en   = wen_q;
   assign rf_write_addr = addr_q;
   assign rf_data       = data_q;
   assign grant_id      = gid_q;

endmodule

// File: tb/tb_riscv_rf_wb_arbiter.sv
// Directed bench for riscv_rf_wb_arbiter: vector table for the
// round-robin/stall/x0 cases plus an async reset sequence.
module tb_riscv_rf_wb_arbiter;

   logic        clk;
   logic        rst;
   logic        stall;
   logic [2:0]  req_valid;
   logic [14:0] req_addr;
   logic [95:0] req_data;
   logic [2:0]  req_ready;
   logic        rf_write_en;
   logic [4:0]  rf_write_addr;
   logic [31:0] rf_data;
   logic [1:0]  grant_id;

   int checks   = 0;
   int failures = 0;

   riscv_rf_wb_arbiter #(
      .WORD_LENGTH(32),
      .ADDR_LENGTH(5),
      .NUM_REQ(3)
   ) dut (
      .clk(clk),
      .rst(rst),
      .stall(stall),
      .req_valid(req_valid),
      .req_addr(req_addr),
      .req_data(req_data),
      .req_ready(req_ready),
      .rf_write_en(rf_write_en),
      .rf_write_addr(rf_write_addr),
      .rf_data(rf_data),
      .grant_id(grant_id)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        stall;
      logic [2:0]  valid;
      logic [14:0] addr;
      logic [95:0] data;
      logic [2:0]  rdy;
      logic        wen;
      logic [4:0]  waddr;
      logic [31:0] wdata;
      logic [1:0]  gid;
   } vec_t;

   localparam logic [31:0] D0 = 32'h1000_0001;
   localparam logic [31:0] D1 = 32'h2000_0002;
   localparam logic [31:0] D2 = 32'h3000_0003;
   localparam logic [14:0] AN = {5'd3, 5'd2, 5'd1};
   localparam logic [14:0] AX = {5'd3, 5'd0, 5'd1};
   localparam logic [95:0] DN = {D2, D1, D0};
   localparam logic [95:0] DX = {D2, 32'hDEAD_BEEF, D0};

   vec_t tbl [15];

   task automatic chk(input string nm, input logic [127:0] act,
                      input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic vec_t mk(logic s, logic [2:0] v, logic [14:0] a,
                               logic [95:0] d, logic [2:0] r, logic w,
                               logic [4:0] wa, logic [31:0] wd,
                               logic [1:0] g);
      vec_t t;
      t.stall = s; t.valid = v; t.addr = a; t.data = d;
      t.rdy = r; t.wen = w; t.waddr = wa; t.wdata = wd; t.gid = g;
      return t;
   endfunction

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      // round robin from ptr=0
      tbl[0]  = mk(0, 3'b111, AN, DN, 3'b001, 1, 5'd1, D0, 2'd0);
      tbl[1]  = mk(0, 3'b111, AN, DN, 3'b010, 1, 5'd2, D1, 2'd1);
      tbl[2]  = mk(0, 3'b111, AN, DN, 3'b100, 1, 5'd3, D2, 2'd2);
      tbl[3]  = mk(0, 3'b111, AN, DN, 3'b001, 1, 5'd1, D0, 2'd0);
      // stall 4 cycles, ptr=1 held
      tbl[4]  = mk(1, 3'b111, AN, DN, 3'b000, 0, 5'd1, D0, 2'd0);
      tbl[5]  = mk(1, 3'b111, AN, DN, 3'b000, 0, 5'd1, D0, 2'd0);
      tbl[6]  = mk(1, 3'b111, AN, DN, 3'b000, 0, 5'd1, D0, 2'd0);
      tbl[7]  = mk(1, 3'b111, AN, DN, 3'b000, 0, 5'd1, D0, 2'd0);
      tbl[8]  = mk(0, 3'b111, AN, DN, 3'b010, 1, 5'd2, D1, 2'd1);
      // x0 write from src1 (ptr=2 wraps scan to 1)
      tbl[9]  = mk(0, 3'b010, AX, DX, 3'b010, 0, 5'd0, 32'hDEAD_BEEF, 2'd1);
      // fairness / wrap
      tbl[10] = mk(0, 3'b111, AN, DN, 3'b100, 1, 5'd3, D2, 2'd2);
      tbl[11] = mk(0, 3'b101, AN, DN, 3'b001, 1, 5'd1, D0, 2'd0);
      tbl[12] = mk(0, 3'b101, AN, DN, 3'b100, 1, 5'd3, D2, 2'd2);
      tbl[13] = mk(0, 3'b000, AN, DN, 3'b000, 0, 5'd3, D2, 2'd2);
      tbl[14] = mk(0, 3'b110, AN, DN, 3'b010, 1, 5'd2, D1, 2'd1);

      rst = 1'b1;
      stall = 1'b0;
      req_valid = 3'b111;
      req_addr = AN;
      req_data = DN;
      @(posedge clk);
      #1;
      chk("rst_ready", 128'(req_ready), 128'(3'b000));
      chk("rst_wen", 128'(rf_write_en), 128'(1'b0));
      chk("rst_addr", 128'(rf_write_addr), 128'(5'd0));
      chk("rst_data", 128'(rf_data), 128'(32'd0));
      chk("rst_gid", 128'(grant_id), 128'(2'd0));
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 15; i++) begin
         stall = tbl[i].stall;
         req_valid = tbl[i].valid;
         req_addr = tbl[i].addr;
         req_data = tbl[i].data;
         #1;
         chk($sformatf("v%0d_ready", i), 128'(req_ready), 128'(tbl[i].rdy));
         @(posedge clk);
         #1;
         chk($sformatf("v%0d_wen", i), 128'(rf_write_en), 128'(tbl[i].wen));
         chk($sformatf("v%0d_addr", i), 128'(rf_write_addr),
             128'(tbl[i].waddr));
         chk($sformatf("v%0d_data", i), 128'(rf_data), 128'(tbl[i].wdata));
         chk($sformatf("v%0d_gid", i), 128'(grant_id), 128'(tbl[i].gid));
         @(negedge clk);
      end

      // async reset while a write is on the port (ptr=2 now)
      stall = 1'b0;
      req_valid = 3'b111;
      req_addr = AN;
      req_data = DN;
      #1;
      chk("ar_ready_pre", 128'(req_ready), 128'(3'b100));
      @(posedge clk);
      #1;
      chk("ar_wen_pre", 128'(rf_write_en), 128'(1'b1));
      chk("ar_addr_pre", 128'(rf_write_addr), 128'(5'd3));
      #1;
      rst = 1'b1;
      #1;
      chk("ar_wen", 128'(rf_write_en), 128'(1'b0));
      chk("ar_addr", 128'(rf_write_addr), 128'(5'd0));
      chk("ar_data", 128'(rf_data), 128'(32'd0));
      chk("ar_gid", 128'(grant_id), 128'(2'd0));
      chk("ar_ready", 128'(req_ready), 128'(3'b000));
      #1;
      rst = 1'b0;
      @(negedge clk);
      #1;
      chk("ar_ready_post", 128'(req_ready), 128'(3'b001));
      chk("ar_wen_post", 128'(rf_write_en), 128'(1'b0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
